qpp_interleaver: RTL and testbench

Parametrised streaming QPP interleaver/deinterleaver for the turbo decoder datapath, sitting between the constituent SISO decoders. It accepts one K-sample frame in natural or permuted order and emits it in the other order, using a two-bank ping-pong buffer. With this structure one frame is written while the previous frame is read, sustaining one sample per cycle. The mode is selectable per frame, so one instance serves both the interleave path and the deinterleave path.

---
 rtl/turbo_pkg.sv | 16 +
 rtl/qpp_interleaver_if.sv | 23 ++
 rtl/qpp_addr_gen.sv | 50 +++++
 rtl/qpp_interleaver.sv | 172 +++++++++++++++++
 tb/tb_qpp_interleaver.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/turbo_pkg.sv
// Shared turbo-decoder definitions: mode encoding, read-FSM states, address sizing.
package turbo_pkg;

  localparam logic MODE_INTERLEAVE   = 1'b0;
  localparam logic MODE_DEINTERLEAVE = 1'b1;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_t;

  function automatic int addr_w(input int k);
    return (k < 2) ? 1 : $clog2(k);
  endfunction

endpackage

// File: rtl/qpp_interleaver_if.sv
// Sample stream bundle for the QPP interleaver: input handshake, mode select, output handshake.
interface qpp_interleaver_if #(
  parameter int DATA_W = 16
);
  logic              mode_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic              out_last_o;

  modport slave (
    input  mode_i, in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_last_o
  );

  modport master (
    output mode_i, in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_last_o
  );
endinterface

// File: rtl/qpp_addr_gen.sv
// Multiplier-free QPP index generator: o_pi steps through pi(0), pi(1), ... on each advance.
// pi and its first difference g are both kept reduced mod K by a single compare-and-subtract.
module qpp_addr_gen
  import turbo_pkg::*;
#(
  parameter int K  = 40,
  parameter int F1 = 3,
  parameter int F2 = 10,
  parameter int AW = addr_w(K)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_advance,
  output logic [AW-1:0] o_pi
);

  localparam logic [AW:0]   KW = (AW + 1)'(K);
  localparam logic [AW-1:0] G0 = AW'((F1 + F2) % K);
  localparam logic [AW-1:0] DG = AW'((2 * F2) % K);

  logic [AW-1:0] r_pi;
  logic [AW-1:0] r_g;
  logic [AW:0]   w_pi_sum;
  logic [AW:0]   w_g_sum;
  logic [AW-1:0] w_pi_nxt;
  logic [AW-1:0] w_g_nxt;

  // Both operands are already < K, so one subtraction is a full reduction.
  assign w_pi_sum = {1'b0, r_pi} + {1'b0, r_g};
  assign w_g_sum  = {1'b0, r_g} + {1'b0, DG};
  assign w_pi_nxt = (w_pi_sum >= KW) ? AW'(w_pi_sum - KW) : AW'(w_pi_sum);
  assign w_g_nxt  = (w_g_sum >= KW) ? AW'(w_g_sum - KW) : AW'(w_g_sum);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pi <= '0;
      r_g  <= G0;
    end else if (i_clear) begin
      r_pi <= '0;
      r_g  <= G0;
    end else if (i_advance) begin
      r_pi <= w_pi_nxt;
      r_g  <= w_g_nxt;
    end
  end

  assign o_pi = r_pi;

endmodule

// File: rtl/qpp_interleaver.sv
// Streaming QPP interleaver/deinterleaver with a two-bank ping-pong buffer, one sample per cycle.
// Write side fills one bank in its own order while the read side drains the other in the opposite order.
module qpp_interleaver
  import turbo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int K      = 40,
  parameter int F1     = 3,
  parameter int F2     = 10
) (
  input logic               clk_p_i,
  input logic               reset_p_i,
  qpp_interleaver_if.slave  bus
);

  localparam int            AW       = addr_w(K);
  localparam logic [AW-1:0] LAST_IDX = AW'(K - 1);

  logic [DATA_W-1:0] r_mem0 [K];
  logic [DATA_W-1:0] r_mem1 [K];

  logic [1:0]        r_full;
  logic [1:0]        r_mode;
  logic              r_wb;
  logic              r_rb;
  logic [AW-1:0]     r_wi;
  logic [AW-1:0]     r_rj;
  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  logic [DATA_W-1:0] r_out_dat;
  logic              r_out_vld;
  logic              r_out_last;

  logic              w_in_rdy;
  logic              w_accept;
  logic              w_wr_last;
  logic              w_wmode;
  logic [AW-1:0]     w_wpi;
  logic [AW-1:0]     w_waddr;
  logic              w_rmode;
  logic [AW-1:0]     w_rpi;
  logic [AW-1:0]     w_raddr;
  logic [DATA_W-1:0] w_rdata;
  logic              w_out_free;
  logic              w_issue;
  logic              w_rd_done;

  // ---------------- write side ----------------
  assign w_in_rdy  = !r_full[r_wb];
  assign w_accept  = bus.in_valid_i && w_in_rdy;
  assign w_wr_last = w_accept && (r_wi == LAST_IDX);
  // The bank's mode flag is only latched at the end of the first write, so sample 0 uses mode_i directly.
  assign w_wmode   = (r_wi == '0) ? bus.mode_i : r_mode[r_wb];
  assign w_waddr   = (w_wmode == MODE_DEINTERLEAVE) ? w_wpi : r_wi;

  qpp_addr_gen #(.K(K), .F1(F1), .F2(F2), .AW(AW)) u_wr_gen (
    .i_clk     (clk_p_i),
    .i_rst     (reset_p_i),
    .i_clear   (w_wr_last),
    .i_advance (w_accept),
    .o_pi      (w_wpi)
  );

  always_ff @(posedge clk_p_i) begin
    if (w_accept) begin
      if (r_wb) r_mem1[w_waddr] <= bus.in_data_i;
      else      r_mem0[w_waddr] <= bus.in_data_i;
    end
  end

  always_ff @(posedge clk_p_i or posedge reset_p_i) begin
    if (reset_p_i) begin
      r_wi   <= '0;
      r_wb   <= 1'b0;
      r_mode <= '0;
    end else if (w_accept) begin
      if (r_wi == '0) r_mode[r_wb] <= bus.mode_i;
      if (w_wr_last) begin
        r_wi <= '0;
        r_wb <= !r_wb;
      end else begin
        r_wi <= r_wi + AW'(1);
      end
    end
  end

  // Fill and drain always target different banks, so both updates can land in one cycle.
  always_ff @(posedge clk_p_i or posedge reset_p_i) begin
    if (reset_p_i) begin
      r_full <= '0;
    end else begin
      if (w_wr_last) r_full[r_wb] <= 1'b1;
      if (w_rd_done) r_full[r_rb] <= 1'b0;
    end
  end

  // ---------------- read side ----------------
  assign w_out_free = !r_out_vld || bus.out_ready_i;
  assign w_rmode    = r_mode[r_rb];
  assign w_raddr    = (w_rmode == MODE_INTERLEAVE) ? w_rpi : r_rj;
  assign w_rdata    = r_rb ? r_mem1[w_raddr] : r_mem0[w_raddr];

  qpp_addr_gen #(.K(K), .F1(F1), .F2(F2), .AW(AW)) u_rd_gen (
    .i_clk     (clk_p_i),
    .i_rst     (reset_p_i),
    .i_clear   (w_rd_done),
    .i_advance (w_issue),
    .o_pi      (w_rpi)
  );

  // Idle issues the first address in the same cycle it sees the bank full, so frames drain gap-free.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_rd_done   = 1'b0;
    case (r_state)
      RD_IDLE: begin
        if (r_full[r_rb]) begin
          w_state_nxt = RD_DRAIN;
          w_issue     = w_out_free;
        end
      end
      RD_DRAIN: begin
        w_issue = w_out_free;
        if (w_out_free && (r_rj == LAST_IDX)) begin
          w_rd_done   = 1'b1;
          w_state_nxt = RD_IDLE;
        end
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_p_i or posedge reset_p_i) begin
    if (reset_p_i) begin
      r_state <= RD_IDLE;
      r_rj    <= '0;
      r_rb    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        if (w_rd_done) begin
          r_rj <= '0;
          r_rb <= !r_rb;
        end else begin
          r_rj <= r_rj + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_p_i or posedge reset_p_i) begin
    if (reset_p_i) begin
      r_out_dat  <= '0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
    end else if (w_issue) begin
      r_out_dat  <= w_rdata;
      r_out_vld  <= 1'b1;
      r_out_last <= (r_rj == LAST_IDX);
    end else if (bus.out_ready_i) begin
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
    end
  end

  assign bus.in_ready_o  = w_in_rdy;
  assign bus.out_valid_o = r_out_vld;
  assign bus.out_data_o  = r_out_dat;
  assign bus.out_last_o  = r_out_last;

endmodule

// File: tb/tb_qpp_interleaver.sv
// Randomized bench for qpp_interleaver: frame-level reference permutation plus an output scoreboard.
module tb_qpp_interleaver;
  import turbo_pkg::*;

  localparam int DW = 16;
  localparam int K  = 40;
  localparam int F1 = 3;
  localparam int F2 = 10;

  typedef struct {
    logic          mode;
    logic [DW-1:0] d;
  } stim_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qpp_interleaver_if #(.DATA_W(DW)) bus ();

  qpp_interleaver #(.DATA_W(DW), .K(K), .F1(F1), .F2(F2)) dut (
    .clk_p_i   (clk),
    .reset_p_i (rst),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int out_cnt  = 0;
  int rdy_mode = 0;

  stim_t         stim_q[$];
  exp_t          exp_q[$];
  logic [DW-1:0] part[$];
  logic          fmode;
  logic [DW-1:0] frame_out [K];
  logic          h_vld;
  logic [DW-1:0] h_dat;
  logic          h_last;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_pi(input int i);
    longint v;
    v = longint'(F1) * i + longint'(F2) * i * i;
    return int'(v % K);
  endfunction

  // kind: 0 = natural ramp, 1 = ramp already interleaved, 2 = random
  task automatic push_frame(input logic mode, input int kind, input int n);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s.mode = mode;
      case (kind)
        0:       s.d = DW'(i);
        1:       s.d = DW'(ref_pi(i));
        default: s.d = DW'($urandom);
      endcase
      stim_q.push_back(s);
    end
  endtask

  task automatic drive(input int gap_pct, input int max_cyc, output int n_acc, output int n_stall);
    bit acc;
    acc     = 1'b1;
    n_acc   = 0;
    n_stall = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (stim_q.size() == 0) break;
      if (acc || !bus.in_valid_i) begin
        if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
          bus.in_valid_i = 1'b0;
        end else begin
          bus.in_valid_i = 1'b1;
          bus.mode_i     = stim_q[0].mode;
          bus.in_data_i  = stim_q[0].d;
        end
      end
      @(negedge clk);
      acc = bus.in_valid_i && bus.in_ready_o;
      if (bus.in_valid_i && !bus.in_ready_o) n_stall++;
      @(posedge clk);
      #1;
      if (acc) begin
        void'(stim_q.pop_front());
        n_acc++;
      end
    end
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    for (int c = 0; c < max_cyc && exp_q.size() > 0; c++) @(posedge clk);
    #1;
    chk_eq(tag, exp_q.size(), 0);
  endtask

  // Downstream ready pattern: 0 = always ready, 1 = stalled, 2 = random
  initial begin
    bus.out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready_i = 1'b1;
        1:       bus.out_ready_i = 1'b0;
        default: bus.out_ready_i = 1'($urandom_range(1));
      endcase
    end
  end

  // Monitor: builds expected frames from accepted input and scores every consumed output.
  initial begin
    exp_t e;
    h_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        part.delete();
        exp_q.delete();
        h_vld = 1'b0;
      end else begin
        if (bus.in_valid_i && bus.in_ready_o) begin
          if (part.size() == 0) fmode = bus.mode_i;
          part.push_back(bus.in_data_i);
          if (part.size() == K) begin
            for (int j = 0; j < K; j++) begin
              if (fmode == MODE_INTERLEAVE) frame_out[j] = part[ref_pi(j)];
              else                          frame_out[ref_pi(j)] = part[j];
            end
            for (int j = 0; j < K; j++) begin
              e.d    = frame_out[j];
              e.last = (j == K - 1);
              exp_q.push_back(e);
            end
            part.delete();
          end
        end
        if (h_vld) begin
          chk_eq("hold_vld", 32'(bus.out_valid_o), 1);
          chk_eq("hold_dat", 32'(bus.out_data_o), 32'(h_dat));
          chk_eq("hold_last", 32'(bus.out_last_o), 32'(h_last));
        end
        if (bus.out_valid_o && bus.out_ready_i) begin
          if (exp_q.size() == 0) begin
            chk_eq("unexpected_out", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk_eq("out_dat", 32'(bus.out_data_o), 32'(e.d));
            chk_eq("out_last", 32'(bus.out_last_o), 32'(e.last));
          end
          out_cnt++;
        end
        h_vld  = bus.out_valid_o && !bus.out_ready_i;
        h_dat  = bus.out_data_o;
        h_last = bus.out_last_o;
      end
    end
  end

  initial begin
    int n_acc, n_stall, base;
    bit seen [K];
    int distinct;

    bus.in_valid_i = 1'b0;
    bus.mode_i     = 1'b0;
    bus.in_data_i  = '0;

    // (F1, F2) must form a permutation polynomial for K
    distinct = 0;
    for (int i = 0; i < K; i++) seen[i] = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (!seen[ref_pi(i)]) distinct++;
      seen[ref_pi(i)] = 1'b1;
    end
    chk_eq("qpp_perm", distinct, K);

    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_in_rdy", 32'(bus.in_ready_o), 1);
    chk_eq("rst_out_vld", 32'(bus.out_valid_o), 0);
    chk_eq("rst_out_dat", 32'(bus.out_data_o), 0);
    chk_eq("rst_out_last", 32'(bus.out_last_o), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Interleave ramp, then check the two-cycle output latency
    rdy_mode = 0;
    push_frame(MODE_INTERLEAVE, 0, K);
    drive(0, 200, n_acc, n_stall);
    chk_eq("lat_t1_vld", 32'(bus.out_valid_o), 0);
    @(posedge clk);
    #1;
    chk_eq("lat_t2_vld", 32'(bus.out_valid_o), 1);
    wait_drain("drain_ilv", 200);

    // Deinterleaving the interleaved ramp restores natural order
    push_frame(MODE_DEINTERLEAVE, 1, K);
    drive(0, 200, n_acc, n_stall);
    wait_drain("drain_dil", 200);

    // Back-to-back frames with alternating mode at full rate
    base = out_cnt;
    for (int f = 0; f < 4; f++) push_frame(1'(f % 2), 2, K);
    drive(0, 400, n_acc, n_stall);
    chk_eq("b2b_acc", n_acc, 4 * K);
    chk_eq("b2b_stall", n_stall, 0);
    wait_drain("drain_b2b", 200);
    chk_eq("b2b_outs", out_cnt - base, 4 * K);

    // Downstream fully stalled: two banks fill, then input backpressures
    base = out_cnt;
    rdy_mode = 1;
    @(posedge clk);
    #1;
    for (int f = 0; f < 3; f++) push_frame(1'($urandom_range(1)), 2, K);
    drive(0, 200, n_acc, n_stall);
    chk_eq("bp_acc", n_acc, 2 * K);
    chk_eq("bp_in_rdy", 32'(bus.in_ready_o), 0);
    chk_eq("bp_out_vld", 32'(bus.out_valid_o), 1);
    chk_eq("bp_out_dat", 32'(bus.out_data_o), 32'(exp_q[0].d));
    rdy_mode = 0;
    drive(0, 400, n_acc, n_stall);
    chk_eq("bp_rest_acc", n_acc, K);
    wait_drain("drain_bp", 400);
    chk_eq("bp_outs", out_cnt - base, 3 * K);

    // Random valid/ready gaps over many frames
    base = out_cnt;
    rdy_mode = 2;
    for (int f = 0; f < 20; f++) push_frame(1'($urandom_range(1)), 2, K);
    drive(50, 20000, n_acc, n_stall);
    chk_eq("rand_acc", n_acc, 20 * K);
    wait_drain("drain_rand", 2000);
    chk_eq("rand_outs", out_cnt - base, 20 * K);

    // Reset in the middle of frame 2 discards everything buffered
    push_frame(MODE_INTERLEAVE, 2, K);
    push_frame(MODE_DEINTERLEAVE, 2, 17);
    drive(0, 400, n_acc, n_stall);
    rst = 1'b1;
    #1;
    chk_eq("mrst_out_vld", 32'(bus.out_valid_o), 0);
    chk_eq("mrst_out_dat", 32'(bus.out_data_o), 0);
    chk_eq("mrst_out_last", 32'(bus.out_last_o), 0);
    chk_eq("mrst_in_rdy", 32'(bus.in_ready_o), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    base = out_cnt;
    rdy_mode = 0;
    push_frame(MODE_INTERLEAVE, 0, K);
    drive(0, 200, n_acc, n_stall);
    wait_drain("drain_post_rst", 200);
    chk_eq("post_rst_outs", out_cnt - base, K);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
